// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, requester indices and arbiter state encoding.
package map_pkg;
  localparam int X_W = 6;
  localparam int Y_W = 5;
  localparam int D_W = 8;
  typedef logic [X_W-1:0] map_x_t;
  typedef logic [Y_W-1:0] map_y_t;
  localparam int REQ_GHOST = 0;
  localparam int REQ_PACMAN = 1;
  localparam int REQ_COLL = 2;
  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;
endpackage

// File: rtl/map_rr_pick.sv
// map_rr_pick: combinational round-robin picker, first asserted req at or above ptr with wrap.
module map_rr_pick import map_pkg::*; #(
  parameter int NREQ = 3,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            vld
);
  always_comb begin
    win = '0;
    vld = |req;
    // scan from farthest offset down so the nearest one above ptr wins
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) win = NREQ'(1) << ((int'(ptr) + k) % NREQ);
  end
endmodule

// File: rtl/map_rd_arbiter.sv
// map_rd_arbiter: round-robin arbiter with locked bursts for the map RAM read port,
// routing fixed-latency read data back to the issuing requester.
module map_rd_arbiter import map_pkg::*; #(
  parameter int NREQ = 3,
  parameter int X_W = map_pkg::X_W,
  parameter int Y_W = map_pkg::Y_W,
  parameter int D_W = map_pkg::D_W,
  parameter int RD_LAT = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ*X_W-1:0] addr_x,
  input  logic [NREQ*Y_W-1:0] addr_y,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rvalid,
  output logic [D_W-1:0]      rdata,
  output logic [X_W-1:0]      ram_rdaddr_x,
  output logic [Y_W-1:0]      ram_rdaddr_y,
  input  logic [D_W-1:0]      ram_data
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  arb_state_e state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt, own, own_nxt, win_idx;
  logic [CW-1:0] lcnt, lcnt_nxt;
  logic [NREQ-1:0] win;
  logic win_vld;
  logic [X_W-1:0] hold_x, sel_x;
  logic [Y_W-1:0] hold_y, sel_y;
  logic [NREQ-1:0] tag [RD_LAT];

  map_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(req), .ptr(ptr), .win(win), .vld(win_vld));

  always_comb begin
    win_idx = '0;
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PW'(i);
      if (gnt[i]) begin
        sel_x = addr_x[i*X_W +: X_W];
        sel_y = addr_y[i*Y_W +: Y_W];
      end
    end
  end

  // lcnt counts granted cycles of the burst, including the arbitration cycle
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    own_nxt = own;
    lcnt_nxt = lcnt;
    gnt = '0;
    if (reset) begin
      gnt = '0;
    end else if (state == ST_IDLE) begin
      gnt = win;
      if (win_vld) begin
        ptr_nxt = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        if (lock[win_idx]) begin
          state_nxt = ST_LOCKED;
          own_nxt = win_idx;
          lcnt_nxt = CW'(1);
        end
      end
    end else begin
      gnt[own] = req[own];
      lcnt_nxt = lcnt + 1'b1;
      if (!req[own] || !lock[own] || lcnt_nxt == CW'(MAX_LOCK)) begin
        state_nxt = ST_IDLE;
        lcnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= '0;
      own <= '0;
      lcnt <= '0;
      hold_x <= '0;
      hold_y <= '0;
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      own <= own_nxt;
      lcnt <= lcnt_nxt;
      if (|gnt) begin
        hold_x <= sel_x;
        hold_y <= sel_y;
      end
      tag[0] <= gnt & req;
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
    end
  end

  assign ram_rdaddr_x = |gnt ? sel_x : hold_x;
  assign ram_rdaddr_y = |gnt ? sel_y : hold_y;
  assign rvalid = reset ? '0 : tag[RD_LAT-1];
  assign rdata = ram_data;
endmodule

// File: tb/tb_map_rd_arbiter.sv
// tb_map_rd_arbiter: directed plus randomized stimulus, reference model feeding a scoreboard
// that a separate monitor drains against the DUT outputs.
module tb_map_rd_arbiter;
  localparam int RD_LAT = 2;
  localparam int MAX_LOCK = 16;

  typedef struct {logic [2:0] g; logic [5:0] x; logic [4:0] y; bit rst;} gexp_t;
  typedef struct {logic [2:0] who; logic [7:0] d; int due;} rexp_t;

  logic clk = 0, reset;
  logic [2:0] req, lock, gnt, rvalid;
  logic [5:0] ax [3];
  logic [4:0] ay [3];
  logic [17:0] addr_x;
  logic [14:0] addr_y;
  logic [7:0] rdata, ram_data;
  logic [5:0] ram_rdaddr_x;
  logic [4:0] ram_rdaddr_y;
  logic [10:0] apipe [RD_LAT];
  int cyc = 0, checks = 0, failures = 0;
  gexp_t gq[$];
  rexp_t rq[$];
  int owner = -1, held = 0, rr = 0, w;
  logic [5:0] last_x = 0;
  logic [4:0] last_y = 0;

  always #5 clk = ~clk;

  assign addr_x = {ax[2], ax[1], ax[0]};
  assign addr_y = {ay[2], ay[1], ay[0]};

  map_rd_arbiter #(.NREQ(3), .X_W(6), .Y_W(5), .D_W(8), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .CLOCK_50(clk), .reset(reset), .req(req), .lock(lock), .addr_x(addr_x), .addr_y(addr_y),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_rdaddr_x(ram_rdaddr_x),
    .ram_rdaddr_y(ram_rdaddr_y), .ram_data(ram_data));

  function automatic logic [7:0] ramf(input logic [5:0] x, input logic [4:0] y);
    return 8'(x * 7) ^ 8'(y * 13) ^ 8'h5a;
  endfunction

  initial for (int i = 0; i < RD_LAT; i++) apipe[i] = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    apipe[0] <= {ram_rdaddr_x, ram_rdaddr_y};
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign ram_data = ramf(apipe[RD_LAT-1][10:5], apipe[RD_LAT-1][4:0]);

  // reference model: evaluates the arbitration rules for the current cycle's inputs
  always @(negedge clk) begin
    gexp_t e;
    e.g = '0;
    e.x = last_x;
    e.y = last_y;
    e.rst = reset;
    if (reset) begin
      rq.delete();
      owner = -1;
      held = 0;
      rr = 0;
      last_x = 0;
      last_y = 0;
    end else begin
      w = -1;
      if (owner < 0) begin
        for (int k = 0; k < 3; k++) if (w < 0 && req[(rr + k) % 3]) w = (rr + k) % 3;
        if (w >= 0) begin
          rr = (w + 1) % 3;
          if (lock[w]) begin
            owner = w;
            held = 1;
          end
        end
      end else begin
        if (req[owner]) w = owner;
        held++;
        if (!req[owner] || !lock[owner] || held == MAX_LOCK) owner = -1;
      end
      if (w >= 0) begin
        e.g[w] = 1'b1;
        e.x = ax[w];
        e.y = ay[w];
        last_x = ax[w];
        last_y = ay[w];
        rq.push_back('{who: 3'(1 << w), d: ramf(ax[w], ay[w]), due: cyc + RD_LAT});
      end
    end
    gq.push_back(e);
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: drains both scoreboard queues against what the DUT presents
  always @(negedge clk) begin
    gexp_t ge;
    rexp_t re;
    #1;
    if (gq.size() == 0) cmp("gq_empty", 1, 0);
    else begin
      ge = gq.pop_front();
      cmp("gnt", int'(gnt), int'(ge.g));
      cmp("ram_rdaddr_x", int'(ram_rdaddr_x), int'(ge.x));
      cmp("ram_rdaddr_y", int'(ram_rdaddr_y), int'(ge.y));
      if (ge.rst) cmp("rvalid_in_reset", int'(rvalid), 0);
      else if (rvalid != 0) begin
        if (rq.size() == 0) cmp("rvalid_unexpected", int'(rvalid), 0);
        else begin
          re = rq.pop_front();
          cmp("rvalid", int'(rvalid), int'(re.who));
          cmp("rdata", int'(rdata), int'(re.d));
          cmp("rvalid_latency", cyc, re.due);
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        re = rq.pop_front();
        cmp("rvalid_missing", 0, int'(re.who));
      end
    end
  end

  task automatic step(input logic [2:0] r, input logic [2:0] l, input int n, input bit rnd);
    repeat (n) begin
      if (rnd) for (int i = 0; i < 3; i++) begin
        ax[i] = 6'($urandom_range(0, 63));
        ay[i] = 5'($urandom_range(0, 31));
      end
      req = r;
      lock = l;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] rr_req, rr_lock;
    reset = 1;
    req = 0;
    lock = 0;
    for (int i = 0; i < 3; i++) begin
      ax[i] = 0;
      ay[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    ax[1] = 5;
    ay[1] = 7;
    step(3'b010, 3'b000, 1, 0);
    step(3'b000, 3'b000, 4, 0);
    step(3'b111, 3'b000, 12, 1);
    step(3'b000, 3'b000, 2, 1);
    step(3'b101, 3'b001, 8, 1);
    step(3'b100, 3'b000, 3, 1);
    step(3'b000, 3'b000, 2, 1);
    step(3'b011, 3'b001, 40, 1);
    step(3'b000, 3'b000, 3, 1);
    ax[0] = 3;
    ay[0] = 4;
    step(3'b001, 3'b000, 1, 0);
    step(3'b000, 3'b000, 5, 0);
    step(3'b001, 3'b001, 1, 1);
    reset = 1;
    step(3'b001, 3'b001, 1, 1);
    step(3'b000, 3'b000, 1, 1);
    reset = 0;
    step(3'b000, 3'b000, 3, 1);
    step(3'b111, 3'b000, 3, 1);
    rr_req = 0;
    rr_lock = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) rr_req[i] = ~rr_req[i];
        if ($urandom_range(0, 5) == 0) rr_lock[i] = ~rr_lock[i];
      end
      reset = ($urandom_range(0, 99) == 0);
      step(rr_req, rr_lock, 1, 1);
    end
    reset = 0;
    step(3'b000, 3'b000, RD_LAT + 4, 0);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
